// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic signal controller and its car sensor conditioner.
package traffic_pkg;

    // Light codes driven by the controller onto each road.
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_e;

    // Loop-detector debounce FSM states. S_FAULT is only reachable when the
    // stuck-sensor detector is compiled in.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUAL    = 3'd1,
        S_PRESENT = 3'd2,
        S_LEAVE   = 3'd3,
        S_FAULT   = 3'd4
    } sensor_state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for an input asynchronous to clock; resets to 0.
module sync_2ff (
    input  logic clock,
    input  logic clear_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only the second stage is used downstream.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/car_sensor_conditioner.sv
// Car sensor conditioner: synchronises and debounces the country-road loop
// detector, keeps a saturating count of waiting cars, retires one car per
// PASS_CYC grant cycles and raises X while any car waits.
// Optional stuck-sensor detection is compiled in with SENSOR_STUCK_DETECT_EN.
// DEBOUNCE_CYC must be at least 2.
module car_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned PASS_CYC     = 8,
    parameter int unsigned CNT_W        = 4
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    parameter int unsigned STUCK_CYC    = 64
`endif
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             sensor_raw,
    input  logic             cntry_grant,
    output logic             X,
    output logic [CNT_W-1:0] car_count,
    output logic             sensor_fault
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned PassW = $clog2(PASS_CYC + 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYC - 1);
    localparam logic [PassW-1:0] PassLast = PassW'(PASS_CYC - 1);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    logic             sync_q;
    sensor_state_e    state_q, state_d;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] car_count_q, car_count_d;
    logic             x_q;
    logic             arrival;
    logic             departure;

    sync_2ff u_sync (
        .clock   (clock),
        .clear_n (clear_n),
        .d_i     (sensor_raw),
        .q_o     (sync_q)
    );

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int unsigned StuckW = $clog2(STUCK_CYC + 1);
    localparam logic [StuckW-1:0] StuckLast = StuckW'(STUCK_CYC - 1);

    logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic              fault_q;
`endif

    // Debounce FSM: qualifies one arrival per car, ignoring bounce on departure.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        arrival   = 1'b0;
`ifdef SENSOR_STUCK_DETECT_EN
        stuck_cnt_d = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sync_q) begin
                    state_d   = S_QUAL;
                    deb_cnt_d = DebW'(1);
                end
            end
            S_QUAL: begin
                if (!sync_q) begin
                    state_d   = S_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    arrival   = 1'b1;
                    state_d   = S_PRESENT;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
            S_PRESENT: begin
                if (!sync_q) begin
                    state_d   = S_LEAVE;
                    deb_cnt_d = DebW'(1);
                end
            end
            S_LEAVE: begin
                if (sync_q) begin
                    // Bounce while leaving: same car, no new arrival.
                    state_d   = S_PRESENT;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d   = S_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
`ifdef SENSOR_STUCK_DETECT_EN
            S_FAULT: begin
                // Leave the fault only after a clean debounced low.
                if (sync_q) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d   = S_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
`endif
            default: begin
                state_d   = S_IDLE;
                deb_cnt_d = '0;
            end
        endcase

`ifdef SENSOR_STUCK_DETECT_EN
        // Consecutive high samples with a car present; overrides the FSM on expiry.
        if ((state_q == S_PRESENT || state_q == S_LEAVE) && sync_q) begin
            if (stuck_cnt_q == StuckLast) begin
                state_d     = S_FAULT;
                deb_cnt_d   = '0;
                stuck_cnt_d = '0;
            end else begin
                stuck_cnt_d = stuck_cnt_q + StuckW'(1);
            end
        end
`endif
    end

    // Pass timer: one departure per PASS_CYC consecutive grant cycles.
    always_comb begin
        pass_cnt_d = '0;
        departure  = 1'b0;
        if (cntry_grant) begin
            if (pass_cnt_q == PassLast) begin
                departure = 1'b1;
            end else begin
                pass_cnt_d = pass_cnt_q + PassW'(1);
            end
        end
    end

    // Waiting-car counter: saturating up, floored down, simultaneous events cancel.
    always_comb begin
        car_count_d = car_count_q;
        if (arrival && !departure) begin
            if (car_count_q != CntMax) begin
                car_count_d = car_count_q + CNT_W'(1);
            end
        end else if (departure && !arrival) begin
            if (car_count_q != '0) begin
                car_count_d = car_count_q - CNT_W'(1);
            end
        end
`ifdef SENSOR_STUCK_DETECT_EN
        if (state_d == S_FAULT) begin
            car_count_d = '0;
        end
`endif
    end

    // State and output registers; X tracks the next count so it moves with car_count.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= S_IDLE;
            deb_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            car_count_q <= '0;
            x_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            car_count_q <= car_count_d;
            x_q         <= (car_count_d != '0);
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    // Stuck-sensor counter and registered fault flag.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stuck_cnt_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign sensor_fault = fault_q;
`else
    assign sensor_fault = 1'b0;
`endif

    assign X         = x_q;
    assign car_count = car_count_q;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Directed self-checking bench for car_sensor_conditioner.
// Expectations for the stuck-sensor scenario follow SENSOR_STUCK_DETECT_EN.
module tb_car_sensor_conditioner;

    logic       clock;
    logic       clear_n;
    logic       sensor_raw;
    logic       cntry_grant;
    logic       X;
    logic [3:0] car_count;
    logic       sensor_fault;

    int checks;
    int failures;

    car_sensor_conditioner dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .sensor_raw   (sensor_raw),
        .cntry_grant  (cntry_grant),
        .X            (X),
        .car_count    (car_count),
        .sensor_fault (sensor_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        clear_n     = 1'b0;
        sensor_raw  = 1'b0;
        cntry_grant = 1'b0;
        tick(2);
        clear_n = 1'b1;
    endtask

    // One clean car: 10 cycles on the loop, 10 cycles clear.
    task automatic add_car();
        sensor_raw = 1'b1;
        tick(10);
        sensor_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        clear_n     = 1'b0;
        sensor_raw  = 1'b0;
        cntry_grant = 1'b0;
        #1;
        checks++; if (X !== 1'b0) begin failures++; $display("FAIL reset_x got %b expected 0", X); end
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL reset_count got %0d expected 0", car_count); end
        checks++; if (sensor_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got %b expected 0", sensor_fault); end
        tick(2);
        clear_n = 1'b1;
    endtask

    task automatic test_single_car();
        apply_reset();
        sensor_raw = 1'b1;
        tick(5);
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL single_edge5_count got %0d expected 0", car_count); end
        checks++; if (X !== 1'b0) begin failures++; $display("FAIL single_edge5_x got %b expected 0", X); end
        tick(1);
        checks++; if (car_count !== 4'd1) begin failures++; $display("FAIL single_edge6_count got %0d expected 1", car_count); end
        checks++; if (X !== 1'b1) begin failures++; $display("FAIL single_edge6_x got %b expected 1", X); end
        tick(4);
        sensor_raw = 1'b0;
        tick(10);
        checks++; if (car_count !== 4'd1) begin failures++; $display("FAIL single_after_fall_count got %0d expected 1", car_count); end
        checks++; if (X !== 1'b1) begin failures++; $display("FAIL single_after_fall_x got %b expected 1", X); end
    endtask

    task automatic test_glitch();
        apply_reset();
        sensor_raw = 1'b1;
        tick(3);
        sensor_raw = 1'b0;
        tick(10);
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL glitch_count got %0d expected 0", car_count); end
        checks++; if (X !== 1'b0) begin failures++; $display("FAIL glitch_x got %b expected 0", X); end
    endtask

    task automatic test_bounce();
        apply_reset();
        sensor_raw = 1'b1;
        tick(10);
        sensor_raw = 1'b0;
        tick(2);
        sensor_raw = 1'b1;
        tick(2);
        sensor_raw = 1'b0;
        tick(10);
        checks++; if (car_count !== 4'd1) begin failures++; $display("FAIL bounce_count got %0d expected 1", car_count); end
        add_car();
        checks++; if (car_count !== 4'd2) begin failures++; $display("FAIL bounce_next_car got %0d expected 2", car_count); end
    endtask

    task automatic test_pass_timer();
        apply_reset();
        repeat (3) add_car();
        checks++; if (car_count !== 4'd3) begin failures++; $display("FAIL pass_start got %0d expected 3", car_count); end
        cntry_grant = 1'b1;
        tick(7);
        checks++; if (car_count !== 4'd3) begin failures++; $display("FAIL pass_g7 got %0d expected 3", car_count); end
        tick(1);
        checks++; if (car_count !== 4'd2) begin failures++; $display("FAIL pass_g8 got %0d expected 2", car_count); end
        tick(7);
        checks++; if (car_count !== 4'd2) begin failures++; $display("FAIL pass_g15 got %0d expected 2", car_count); end
        tick(1);
        checks++; if (car_count !== 4'd1) begin failures++; $display("FAIL pass_g16 got %0d expected 1", car_count); end
        tick(7);
        checks++; if (X !== 1'b1) begin failures++; $display("FAIL pass_g23_x got %b expected 1", X); end
        tick(1);
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL pass_g24 got %0d expected 0", car_count); end
        checks++; if (X !== 1'b0) begin failures++; $display("FAIL pass_g24_x got %b expected 0", X); end
        tick(8);
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL pass_floor got %0d expected 0", car_count); end
        cntry_grant = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        repeat (17) add_car();
        checks++; if (car_count !== 4'd15) begin failures++; $display("FAIL sat_count got %0d expected 15", car_count); end
        checks++; if (X !== 1'b1) begin failures++; $display("FAIL sat_x got %b expected 1", X); end
        // Arrival at raw edge 6 lands on the 8th grant edge.
        cntry_grant = 1'b1;
        tick(2);
        sensor_raw = 1'b1;
        tick(5);
        checks++; if (car_count !== 4'd15) begin failures++; $display("FAIL sat_pre_both got %0d expected 15", car_count); end
        tick(1);
        checks++; if (car_count !== 4'd15) begin failures++; $display("FAIL sat_both got %0d expected 15", car_count); end
        cntry_grant = 1'b0;
        tick(1);
        checks++; if (car_count !== 4'd15) begin failures++; $display("FAIL sat_after_both got %0d expected 15", car_count); end
        sensor_raw = 1'b0;
        tick(10);
    endtask

    task automatic test_stuck();
        apply_reset();
        sensor_raw = 1'b1;
        tick(6);
        checks++; if (car_count !== 4'd1) begin failures++; $display("FAIL stuck_edge6 got %0d expected 1", car_count); end
        tick(63);
        checks++; if (sensor_fault !== 1'b0) begin failures++; $display("FAIL stuck_edge69_fault got %b expected 0", sensor_fault); end
        tick(1);
`ifdef SENSOR_STUCK_DETECT_EN
        checks++; if (sensor_fault !== 1'b1) begin failures++; $display("FAIL stuck_edge70_fault got %b expected 1", sensor_fault); end
        checks++; if (X !== 1'b0) begin failures++; $display("FAIL stuck_edge70_x got %b expected 0", X); end
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL stuck_edge70_count got %0d expected 0", car_count); end
`else
        checks++; if (sensor_fault !== 1'b0) begin failures++; $display("FAIL stuck_edge70_fault got %b expected 0", sensor_fault); end
        checks++; if (X !== 1'b1) begin failures++; $display("FAIL stuck_edge70_x got %b expected 1", X); end
        checks++; if (car_count !== 4'd1) begin failures++; $display("FAIL stuck_edge70_count got %0d expected 1", car_count); end
`endif
        sensor_raw = 1'b0;
        tick(6);
        checks++; if (sensor_fault !== 1'b0) begin failures++; $display("FAIL stuck_release_fault got %b expected 0", sensor_fault); end
    endtask

    task automatic test_async_clear();
        apply_reset();
        repeat (2) add_car();
        sensor_raw = 1'b1;
        tick(4);
        checks++; if (car_count !== 4'd2) begin failures++; $display("FAIL clear_pre_count got %0d expected 2", car_count); end
        // Assert reset mid-cycle, well away from any rising edge.
        #2;
        clear_n = 1'b0;
        #1;
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL clear_async_count got %0d expected 0", car_count); end
        checks++; if (X !== 1'b0) begin failures++; $display("FAIL clear_async_x got %b expected 0", X); end
        checks++; if (sensor_fault !== 1'b0) begin failures++; $display("FAIL clear_async_fault got %b expected 0", sensor_fault); end
        tick(1);
        clear_n = 1'b1;
        tick(5);
        checks++; if (car_count !== 4'd0) begin failures++; $display("FAIL clear_requal_edge5 got %0d expected 0", car_count); end
        tick(1);
        checks++; if (car_count !== 4'd1) begin failures++; $display("FAIL clear_requal_edge6 got %0d expected 1", car_count); end
        sensor_raw = 1'b0;
        tick(10);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_car();
        test_glitch();
        test_bounce();
        test_pass_timer();
        test_saturate();
        test_stuck();
        test_async_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
